line_fetch_sched: RTL and testbench
===================================

// Module: line_fetch_sched
// PURPOSE
//  Services per-output-line fetch requests (fetch_en/fetch_line) from the scaler output controller.
//  Bilinear output needs source lines y0 and y1 = min(y0+1, vin_yres-1) resident in a 2-slot line buffer.
//  Each slot carries a line tag; a hit reuses the slot, a miss issues a DDR read burst and writes the line buffer.
//  Pulses ram_ready when both lines are resident. Sits between vout_ctrl, the DDR read port and the line-buffer RAM.
// PARAMETERS
//  DATA_W      64          DDR read data width (bits)
//  PIX_PER_W   4           pixels per DDR word, power of two
//  ADDR_W      32          DDR byte address width
//  BASE_ADDR   32'h0       frame base byte address
//  LINE_STRIDE 32'h2000    bytes between source lines
//  LB_AW       10          line-buffer word address width (one slot = 2**LB_AW words)
// PORTS
//  vin_clk      in   1       clock
//  rst_n        in   1       async active-low reset
//  frame_sync_n in   1       sync active-low frame restart
//  vin_xres     in   16      source width, pixels
//  vin_yres     in   16      source height, lines
//  fetch_en     in   1       1-cycle fetch request
//  fetch_line   in   16      y0, valid with fetch_en
//  ram_ready    out  1       1-cycle pulse: y0,y1 resident
//  top_slot     out  1       slot holding y0, stable from ram_ready to next fetch_en
//  bot_slot     out  1       slot holding y1
//  rd_req       out  1       DDR read request, held until rd_ack
//  rd_addr      out  ADDR_W  BASE_ADDR + line*LINE_STRIDE
//  rd_len       out  16      burst length, words = ceil(vin_xres/PIX_PER_W)
//  rd_ack       in   1       request accepted
//  rd_valid     in   1       read data beat
//  rd_data      in   DATA_W  read data
//  lb_we        out  1       line-buffer write strobe
//  lb_slot      out  1       slot being written
//  lb_addr      out  LB_AW   word index within slot
//  lb_wdata     out  DATA_W  = rd_data, registered
//  err_overrun  out  1       sticky: fetch_en while busy; cleared by frame_sync_n
// BEHAVIOUR
//  Reset: all outputs 0; tags invalid; state IDLE.
//  FSM: IDLE -> LOOKUP on fetch_en; capture y0, compute y1 (clamped).
//   LOOKUP: compare y0,y1 to slot tags; a miss is assigned a slot not holding a needed line.
//    No miss -> DONE. Otherwise REQ for the first missing line (y0 before y1).
//   REQ: rd_req=1 with rd_addr/rd_len stable until the rd_ack cycle; then DATA.
//   DATA: each rd_valid -> lb_we next cycle, lb_addr 0..rd_len-1.
//    Tag invalidated at REQ entry, written valid after the last beat.
//    After the last beat: next missing line -> REQ, else DONE.
//   DONE: ram_ready=1 for one cycle; top_slot/bot_slot update; -> IDLE.
//  Latency: hit -> ram_ready 2 cycles after fetch_en. Miss -> 1 cycle after the last lb_we.
//  y0 == y1 (last line): one slot; top_slot == bot_slot; at most one burst.
//  Beats beyond rd_len are discarded. rd_len is clamped to 2**LB_AW.
//  fetch_en outside IDLE: ignored, err_overrun set.
//  fetch_en and DONE in the same cycle: DONE has priority; the request is ignored and flagged.
//  frame_sync_n low:
//   - invalidate tags; clear err_overrun; no ram_ready.
//   - from REQ before ack: drop rd_req -> IDLE.
//   - after ack: DRAIN, discard remaining beats of the burst (no lb_we) -> IDLE.
//  rd_addr arithmetic: 16x32 multiply, truncated to ADDR_W.
// STRUCTURE
//  Package lfs_pkg:
//   - state enum (IDLE, LOOKUP, REQ, DATA, DRAIN, DONE)
//   - tag record {valid, line[15:0]}
//   - function words_per_line(xres)
//  Sub-module lfs_tag_lookup: combinational hit/miss and slot assignment from 2 tags + y0/y1.
// TESTING
//  Cold start, vin_xres=16, PIX_PER_W=4, fetch_line=0:
//   -> 2 bursts, line 0 then line 1, rd_len=4, rd_addr 0 then 0x2000; 8 lb_we; 1 ram_ready; top=0, bot=1.
//  Then fetch_line=0 again -> no rd_req; ram_ready 2 cycles after fetch_en.
//  Then fetch_line=1 -> one burst, line 2 into slot 0; top_slot=1, bot_slot=0.
//  vin_yres=8, fetch_line=7 -> single burst, top_slot==bot_slot.
//  frame_sync_n low after rd_ack, 2 of 4 beats delivered:
//   -> no further lb_we, no ram_ready; next fetch misses both lines.
//  fetch_en during DATA -> err_overrun=1; the in-flight fetch still completes with one ram_ready.

Source files
------------

// File: rtl/lfs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfs_pkg                                                              |
// | Shared types and helpers for the line fetch scheduler.               |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package lfs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_REQ    = 3'd2,
    ST_DATA   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // One line-buffer slot: which source line it holds, if any.
  typedef struct packed {
    logic        valid;
    logic [15:0] line;
  } tag_t;

  // DDR words needed for one source line: ceil(xres / 2**pix_shift).
  function automatic logic [16:0] words_per_line(input logic [15:0] xres,
                                                 input int unsigned pix_shift);
    logic [16:0] round_up;
    round_up = (17'd1 << pix_shift) - 17'd1;
    return ({1'b0, xres} + round_up) >> pix_shift;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfs_tag_lookup.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfs_tag_lookup                                                       |
// | Hit/miss test of lines y0,y1 against the two slot tags, and slot     |
// | choice for every line (hit slot, or a slot holding no needed line).  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module lfs_tag_lookup
  import lfs_pkg::*;
(
  input  tag_t        tag0,
  input  tag_t        tag1,
  input  logic [15:0] y0,
  input  logic [15:0] y1,
  output logic        y0_hit,
  output logic        y1_hit,
  output logic        y0_slot,
  output logic        y1_slot
);

  logic y0_in_s0, y0_in_s1, y1_in_s0, y1_in_s1;

  assign y0_in_s0 = tag0.valid && (tag0.line == y0);
  assign y0_in_s1 = tag1.valid && (tag1.line == y0);
  assign y1_in_s0 = tag0.valid && (tag0.line == y1);
  assign y1_in_s1 = tag1.valid && (tag1.line == y1);

  // Resolve hits; a missing line takes the slot the other line does not use.
  always_comb begin
    y0_hit  = y0_in_s0 | y0_in_s1;
    y1_hit  = y1_in_s0 | y1_in_s1;
    y0_slot = 1'b0;
    y1_slot = 1'b1;
    if (y0 == y1) begin
      // Last source line: both rows share one slot.
      y0_slot = y0_hit ? !y0_in_s0 : 1'b0;
      y1_slot = y0_slot;
      y1_hit  = y0_hit;
    end else if (y0_hit && y1_hit) begin
      y0_slot = !y0_in_s0;
      y1_slot = !y1_in_s0;
    end else if (y0_hit) begin
      y0_slot = !y0_in_s0;
      y1_slot = y0_in_s0;
    end else if (y1_hit) begin
      y1_slot = !y1_in_s0;
      y0_slot = y1_in_s0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/line_fetch_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | line_fetch_sched                                                     |
// | Keeps source lines y0 and y1 resident in a 2-slot line buffer,       |
// | fetching missing lines by DDR burst, and pulses ram_ready when both  |
// | are available. LB_AW must not exceed 15 (rd_len is 16 bits).         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module line_fetch_sched
  import lfs_pkg::*;
#(
  parameter int               DATA_W      = 64,
  parameter int               PIX_PER_W   = 4,
  parameter int               ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]      LINE_STRIDE = 32'h2000,
  parameter int               LB_AW       = 10
) (
  input  logic              vin_clk,
  input  logic              rst_n,
  input  logic              frame_sync_n,
  input  logic [15:0]       vin_xres,
  input  logic [15:0]       vin_yres,
  input  logic              fetch_en,
  input  logic [15:0]       fetch_line,
  output logic              ram_ready,
  output logic              top_slot,
  output logic              bot_slot,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_len,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              lb_we,
  output logic              lb_slot,
  output logic [LB_AW-1:0]  lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              err_overrun
);

  localparam int          PIX_SHIFT = $clog2(PIX_PER_W);
  localparam logic [16:0] MAX_WORDS = 17'd1 << LB_AW;

  state_e              state_q, state_d;
  logic [15:0]         y0_q, y0_d, y1_q, y1_d;
  logic                slot0_q, slot0_d, slot1_q, slot1_d;
  logic                need1_q, need1_d;
  logic [15:0]         cur_line_q, cur_line_d;
  logic                cur_slot_q, cur_slot_d;
  logic                cur_y1_q, cur_y1_d;
  tag_t                tag_q [2];
  tag_t                tag_d [2];
  logic                rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [15:0]         rd_len_q, rd_len_d;
  logic [15:0]         beat_q, beat_d;
  logic                lb_we_q, lb_we_d;
  logic                lb_slot_q, lb_slot_d;
  logic [LB_AW-1:0]    lb_addr_q, lb_addr_d;
  logic [DATA_W-1:0]   lb_wdata_q, lb_wdata_d;
  logic                ram_ready_q, ram_ready_d;
  logic                top_slot_q, top_slot_d, bot_slot_q, bot_slot_d;
  logic                err_q, err_d;

  logic [16:0]         words_raw;
  logic [15:0]         line_words;
  logic [15:0]         fetch_y1;
  logic                y0_hit, y1_hit, y0_slot, y1_slot;
  logic                start_req, start_slot, start_y1;
  logic [15:0]         start_line;

  assign words_raw  = words_per_line(vin_xres, PIX_SHIFT);
  assign line_words = (words_raw > MAX_WORDS) ? MAX_WORDS[15:0] : words_raw[15:0];

  // Second row: y0+1, clamped to the last source line.
  always_comb begin
    if (vin_yres == 16'd0) begin
      fetch_y1 = fetch_line;
    end else if (({1'b0, fetch_line} + 17'd1) > {1'b0, vin_yres - 16'd1}) begin
      fetch_y1 = vin_yres - 16'd1;
    end else begin
      fetch_y1 = fetch_line + 16'd1;
    end
  end

  lfs_tag_lookup u_lookup (
    .tag0    (tag_q[0]),
    .tag1    (tag_q[1]),
    .y0      (y0_q),
    .y1      (y1_q),
    .y0_hit  (y0_hit),
    .y1_hit  (y1_hit),
    .y0_slot (y0_slot),
    .y1_slot (y1_slot)
  );

  // Next-state and output decode; frame restart overrides everything last.
  always_comb begin
    state_d     = state_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    need1_d     = need1_q;
    cur_line_d  = cur_line_q;
    cur_slot_d  = cur_slot_q;
    cur_y1_d    = cur_y1_q;
    tag_d       = tag_q;
    rd_addr_d   = rd_addr_q;
    rd_len_d    = rd_len_q;
    beat_d      = beat_q;
    lb_we_d     = 1'b0;
    lb_slot_d   = lb_slot_q;
    lb_addr_d   = lb_addr_q;
    lb_wdata_d  = lb_wdata_q;
    ram_ready_d = 1'b0;
    top_slot_d  = top_slot_q;
    bot_slot_d  = bot_slot_q;
    err_d       = err_q | (fetch_en & (state_q != ST_IDLE));
    start_req   = 1'b0;
    start_line  = y0_q;
    start_slot  = 1'b0;
    start_y1    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fetch_en) begin
          y0_d    = fetch_line;
          y1_d    = fetch_y1;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        slot0_d = y0_slot;
        slot1_d = y1_slot;
        need1_d = !y1_hit && (y0_q != y1_q);
        if (!y0_hit) begin
          start_req  = 1'b1;
          start_line = y0_q;
          start_slot = y0_slot;
        end else if (need1_d) begin
          start_req  = 1'b1;
          start_line = y1_q;
          start_slot = y1_slot;
          start_y1   = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_REQ: begin
        if (rd_ack) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (beat_q == rd_len_q) begin
          // Final write is in flight this cycle; the slot now holds the line.
          tag_d[cur_slot_q] = {1'b1, cur_line_q};
          if (!cur_y1_q && need1_q) begin
            start_req  = 1'b1;
            start_line = y1_q;
            start_slot = slot1_q;
            start_y1   = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else if (rd_valid) begin
          lb_we_d    = 1'b1;
          lb_slot_d  = cur_slot_q;
          lb_addr_d  = beat_q[LB_AW-1:0];
          lb_wdata_d = rd_data;
          beat_d     = beat_q + 16'd1;
        end
      end
      ST_DRAIN: begin
        if (beat_q == rd_len_q) state_d = ST_IDLE;
        else if (rd_valid)      beat_d  = beat_q + 16'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (start_req) begin
      cur_line_d              = start_line;
      cur_slot_d              = start_slot;
      cur_y1_d                = start_y1;
      tag_d[start_slot].valid = 1'b0;
      rd_addr_d = BASE_ADDR + ADDR_W'(48'(start_line) * 48'(LINE_STRIDE));
      rd_len_d  = line_words;
      beat_d    = '0;
      state_d   = ST_REQ;
    end

    if (state_d == ST_DONE) begin
      ram_ready_d = 1'b1;
      top_slot_d  = slot0_d;
      bot_slot_d  = slot1_d;
    end

    if (!frame_sync_n) begin
      tag_d[0].valid = 1'b0;
      tag_d[1].valid = 1'b0;
      err_d          = 1'b0;
      ram_ready_d    = 1'b0;
      top_slot_d     = top_slot_q;
      bot_slot_d     = bot_slot_q;
      lb_we_d        = 1'b0;
      case (state_q)
        ST_REQ:            state_d = rd_ack ? ST_DRAIN : ST_IDLE;
        ST_DATA, ST_DRAIN: state_d = ST_DRAIN;
        default:           state_d = ST_IDLE;
      endcase
    end

    rd_req_d = (state_d == ST_REQ);
  end

  // State and output registers.
  always_ff @(posedge vin_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      y0_q        <= '0;
      y1_q        <= '0;
      slot0_q     <= 1'b0;
      slot1_q     <= 1'b0;
      need1_q     <= 1'b0;
      cur_line_q  <= '0;
      cur_slot_q  <= 1'b0;
      cur_y1_q    <= 1'b0;
      for (int i = 0; i < 2; i++) tag_q[i] <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_len_q    <= '0;
      beat_q      <= '0;
      lb_we_q     <= 1'b0;
      lb_slot_q   <= 1'b0;
      lb_addr_q   <= '0;
      lb_wdata_q  <= '0;
      ram_ready_q <= 1'b0;
      top_slot_q  <= 1'b0;
      bot_slot_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      need1_q     <= need1_d;
      cur_line_q  <= cur_line_d;
      cur_slot_q  <= cur_slot_d;
      cur_y1_q    <= cur_y1_d;
      tag_q       <= tag_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      rd_len_q    <= rd_len_d;
      beat_q      <= beat_d;
      lb_we_q     <= lb_we_d;
      lb_slot_q   <= lb_slot_d;
      lb_addr_q   <= lb_addr_d;
      lb_wdata_q  <= lb_wdata_d;
      ram_ready_q <= ram_ready_d;
      top_slot_q  <= top_slot_d;
      bot_slot_q  <= bot_slot_d;
      err_q       <= err_d;
    end
  end

  assign ram_ready   = ram_ready_q;
  assign top_slot    = top_slot_q;
  assign bot_slot    = bot_slot_q;
  assign rd_req      = rd_req_q;
  assign rd_addr     = rd_addr_q;
  assign rd_len      = rd_len_q;
  assign lb_we       = lb_we_q;
  assign lb_slot     = lb_slot_q;
  assign lb_addr     = lb_addr_q;
  assign lb_wdata    = lb_wdata_q;
  assign err_overrun = err_q;

endmodule
`default_nettype wire

// File: tb/tb_line_fetch_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_line_fetch_sched                                                  |
// | Directed stimulus with expected DDR requests, line-buffer writes and |
// | ready events queued up front and checked by a negedge monitor.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_line_fetch_sched;

  logic        vin_clk      = 1'b0;
  logic        rst_n        = 1'b0;
  logic        frame_sync_n = 1'b1;
  logic [15:0] vin_xres     = 16'd16;
  logic [15:0] vin_yres     = 16'd480;
  logic        fetch_en     = 1'b0;
  logic [15:0] fetch_line   = 16'd0;
  logic        rd_ack       = 1'b0;
  logic        rd_valid     = 1'b0;
  logic [63:0] rd_data      = '0;
  logic        ram_ready, top_slot, bot_slot, rd_req;
  logic [31:0] rd_addr;
  logic [15:0] rd_len;
  logic        lb_we, lb_slot, err_overrun;
  logic [9:0]  lb_addr;
  logic [63:0] lb_wdata;

  int checks = 0;
  int errors = 0;
  int lb_we_count = 0;

  logic [47:0] req_q [$];   // {rd_addr, rd_len}
  logic [74:0] wr_q  [$];   // {lb_slot, lb_addr, lb_wdata}
  logic [1:0]  rdy_q [$];   // {top_slot, bot_slot}

  line_fetch_sched dut (
    .vin_clk      (vin_clk),
    .rst_n        (rst_n),
    .frame_sync_n (frame_sync_n),
    .vin_xres     (vin_xres),
    .vin_yres     (vin_yres),
    .fetch_en     (fetch_en),
    .fetch_line   (fetch_line),
    .ram_ready    (ram_ready),
    .top_slot     (top_slot),
    .bot_slot     (bot_slot),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_len       (rd_len),
    .rd_ack       (rd_ack),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .lb_we        (lb_we),
    .lb_slot      (lb_slot),
    .lb_addr      (lb_addr),
    .lb_wdata     (lb_wdata),
    .err_overrun  (err_overrun)
  );

  always #5 vin_clk = ~vin_clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h expected=none", name, act);
  endtask

  function automatic logic [63:0] beat_data(input logic [15:0] line, input int i);
    return {16'hDA7A, line, 32'(i)};
  endfunction

  // Monitor: every DUT transaction is popped against the scoreboard.
  always @(negedge vin_clk) begin
    if (rst_n) begin
      if (rd_req && rd_ack) begin
        if (req_q.size() == 0) unexpected("unexpected_rd_req", {rd_addr, rd_len});
        else chk("rd_addr_len", {rd_addr, rd_len}, req_q.pop_front());
      end
      if (lb_we) begin
        lb_we_count++;
        if (wr_q.size() == 0) unexpected("unexpected_lb_we", {lb_slot, lb_addr, lb_wdata});
        else chk("lb_write", {lb_slot, lb_addr, lb_wdata}, wr_q.pop_front());
      end
      if (ram_ready) begin
        if (rdy_q.size() == 0) unexpected("unexpected_ram_ready", {top_slot, bot_slot});
        else chk("ready_slots", {top_slot, bot_slot}, rdy_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge vin_clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] line);
    fetch_en   = 1'b1;
    fetch_line = line;
    step();
    fetch_en   = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!rd_req && n < 40) begin
      step();
      n++;
    end
    chk("rd_req_seen", rd_req, 1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ram_ready && n < 40) begin
      step();
      n++;
    end
    chk("ram_ready_seen", ram_ready, 1);
    step();
  endtask

  // Accept one request and return nbeats beats; the first nexp are expected
  // in the line buffer. A fetch_en is raised alongside beat ovr_at.
  task automatic serve(input logic [15:0] line, input logic slot, input int nbeats,
                       input int nexp, input int ovr_at);
    wait_req();
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (i < nexp) wr_q.push_back({slot, 10'(i), beat_data(line, i)});
      rd_valid = 1'b1;
      rd_data  = beat_data(line, i);
      fetch_en = (i == ovr_at);
      if (i == ovr_at) fetch_line = 16'd100;
      step();
    end
    rd_valid = 1'b0;
    fetch_en = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    chk("reset_ctrl", {ram_ready, top_slot, bot_slot, rd_req, lb_we, lb_slot, err_overrun}, 0);
    chk("reset_rd", {rd_addr, rd_len}, 0);
    chk("reset_lb", {lb_addr, lb_wdata}, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Cold start: lines 0 and 1 both missing.
    req_q.push_back({32'h0000_0000, 16'd4});
    req_q.push_back({32'h0000_2000, 16'd4});
    rdy_q.push_back(2'b01);
    fetch(16'd0);
    serve(16'd0, 1'b0, 4, 4, -1);
    serve(16'd1, 1'b1, 4, 4, -1);
    wait_ready();
    chk("cold_lb_we_count", lb_we_count, 8);

    // Repeat line 0: pure hit, ready two cycles after the request.
    rdy_q.push_back(2'b01);
    fetch(16'd0);
    chk("hit_not_ready_c1", ram_ready, 0);
    chk("hit_no_rd_req", rd_req, 0);
    step();
    chk("hit_ready_c2", ram_ready, 1);
    repeat (3) step();
    chk("hit_still_no_rd_req", rd_req, 0);

    // Line 1 hits slot 1, line 2 goes into slot 0; a fifth beat is surplus.
    req_q.push_back({32'h0000_4000, 16'd4});
    rdy_q.push_back(2'b10);
    fetch(16'd1);
    serve(16'd2, 1'b0, 5, 4, -1);
    chk("miss_ready_after_last_we", ram_ready, 1);
    chk("surplus_beat_dropped", lb_we, 0);
    repeat (2) step();

    // Last source line: y1 clamps to y0, one burst, one slot.
    vin_yres = 16'd8;
    req_q.push_back({32'h0000_E000, 16'd4});
    rdy_q.push_back(2'b00);
    fetch(16'd7);
    serve(16'd7, 1'b0, 4, 4, -1);
    chk("last_line_final_we", lb_we, 1);
    chk("last_line_not_ready_yet", ram_ready, 0);
    step();
    chk("last_line_ready", ram_ready, 1);
    repeat (3) step();
    chk("last_line_single_burst", rd_req, 0);

    // Overrun: fetch_en during DATA is flagged and otherwise ignored.
    vin_yres = 16'd480;
    req_q.push_back({32'h0001_4000, 16'd4});
    req_q.push_back({32'h0001_6000, 16'd4});
    rdy_q.push_back(2'b01);
    fetch(16'd10);
    serve(16'd10, 1'b0, 4, 4, 1);
    chk("overrun_flag_set", err_overrun, 1);
    serve(16'd11, 1'b1, 4, 4, -1);
    wait_ready();
    repeat (3) step();
    chk("overrun_one_ready", rdy_q.size(), 0);
    chk("overrun_flag_sticky", err_overrun, 1);

    // Frame restart after 2 of 4 beats: rest of burst is discarded.
    req_q.push_back({32'h0001_8000, 16'd4});
    fetch(16'd12);
    serve(16'd12, 1'b0, 2, 2, -1);
    step();
    frame_sync_n = 1'b0;
    step();
    frame_sync_n = 1'b1;
    chk("fsync_err_cleared", err_overrun, 0);
    for (int i = 2; i < 4; i++) begin
      rd_valid = 1'b1;
      rd_data  = beat_data(16'd12, i);
      step();
    end
    rd_valid = 1'b0;
    repeat (4) step();
    chk("fsync_no_rd_req", rd_req, 0);
    chk("fsync_lb_we_count", lb_we_count, 26);

    // After the restart line 11 (previously in slot 1) must miss too.
    req_q.push_back({32'h0001_6000, 16'd4});
    req_q.push_back({32'h0001_8000, 16'd4});
    rdy_q.push_back(2'b01);
    fetch(16'd11);
    serve(16'd11, 1'b0, 4, 4, -1);
    serve(16'd12, 1'b1, 4, 4, -1);
    wait_ready();
    repeat (3) step();

    chk("req_queue_drained", req_q.size(), 0);
    chk("write_queue_drained", wr_q.size(), 0);
    chk("ready_queue_drained", rdy_q.size(), 0);
    chk("total_lb_we", lb_we_count, 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
